// File: rtl/rv32i_regfile_sb.sv
// rv32i_regfile_sb: RV32I integer register file (x0..x31) with a per-register pending-write scoreboard.
// Optional same-cycle writeback bypass on the read ports: define RV32I_RF_WB_BYPASS_EN.

module rv32i_regfile_sb_chk #(
   parameter int NREGS = 32
) (
   input logic             clk,
   input logic             rst,
   input logic [NREGS-1:0] dec_at_zero,
   input logic [NREGS-1:0] inc_at_sat
);

   // A commit must always retire a previously issued write.
   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      dec_at_zero == {NREGS{1'b0}});

   // Decode must honour issue_ok and never push a saturated counter.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      inc_at_sat == {NREGS{1'b0}});

endmodule

module rv32i_regfile_sb #(
   parameter int NREGS    = 32,
   parameter int SB_CNT_W = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  rs1_addr_i,
   output logic [31:0] rs1_rdata_o,
   output logic        rs1_busy_o,
   input  logic [4:0]  rs2_addr_i,
   output logic [31:0] rs2_rdata_o,
   output logic        rs2_busy_o,
   input  logic        rd_we_i,
   input  logic [4:0]  rd_addr_i,
   input  logic [31:0] rd_wdata_i,
   input  logic        issue_i,
   input  logic [4:0]  issue_rd_i,
   output logic        issue_ok_o,
   input  logic        flush_i
);

   localparam logic [SB_CNT_W-1:0] CNT_ZERO = {SB_CNT_W{1'b0}};
   localparam logic [SB_CNT_W-1:0] CNT_ONE  = SB_CNT_W'(1);
   localparam logic [SB_CNT_W-1:0] CNT_SAT  = {SB_CNT_W{1'b1}};

   logic [31:0]         regs_r      [NREGS];
   logic [SB_CNT_W-1:0] cnt_r       [NREGS];
   logic [SB_CNT_W-1:0] cnt_nxt_s   [NREGS];
   logic [NREGS-1:0]    inc_s;
   logic [NREGS-1:0]    dec_s;
   logic [NREGS-1:0]    dec_at_zero_s;
   logic [NREGS-1:0]    inc_at_sat_s;

`ifdef RV32I_RF_WB_BYPASS_EN
   logic wb_hit1_s;
   logic wb_hit2_s;
`endif

   // Architectural state; x0 is never written so it reads as zero forever.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_r[r] <= 32'd0;
         end
      end else if (rd_we_i && (rd_addr_i != 5'd0)) begin
         regs_r[rd_addr_i] <= rd_wdata_i;
      end
   end

   // Per-register in-flight counter next state: saturating, flush wins over inc/dec.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         inc_s[r]         = issue_i && (issue_rd_i == 5'(r)) && (5'(r) != 5'd0);
         dec_s[r]         = rd_we_i && (rd_addr_i == 5'(r)) && (5'(r) != 5'd0);
         dec_at_zero_s[r] = dec_s[r] && !inc_s[r] && (cnt_r[r] == CNT_ZERO);
         inc_at_sat_s[r]  = inc_s[r] && !dec_s[r] && (cnt_r[r] == CNT_SAT);
         if (flush_i) begin
            cnt_nxt_s[r] = CNT_ZERO;
         end else if (inc_s[r] && !dec_s[r] && (cnt_r[r] != CNT_SAT)) begin
            cnt_nxt_s[r] = cnt_r[r] + CNT_ONE;
         end else if (dec_s[r] && !inc_s[r] && (cnt_r[r] != CNT_ZERO)) begin
            cnt_nxt_s[r] = cnt_r[r] - CNT_ONE;
         end else begin
            cnt_nxt_s[r] = cnt_r[r];
         end
      end
   end

   // Scoreboard counter state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int r = 0; r < NREGS; r++) begin
            cnt_r[r] <= CNT_ZERO;
         end
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            cnt_r[r] <= cnt_nxt_s[r];
         end
      end
   end

`ifdef RV32I_RF_WB_BYPASS_EN
   assign wb_hit1_s = rd_we_i && (rd_addr_i == rs1_addr_i) && (rs1_addr_i != 5'd0);
   assign wb_hit2_s = rd_we_i && (rd_addr_i == rs2_addr_i) && (rs2_addr_i != 5'd0);
`endif

   // Read port 1; a bypass hit sees the counter as if this commit had already retired.
   always_comb begin
      rs1_rdata_o = 32'd0;
      rs1_busy_o  = 1'b0;
      if (rst_i) begin
         rs1_rdata_o = 32'd0;
         rs1_busy_o  = 1'b0;
      end
`ifdef RV32I_RF_WB_BYPASS_EN
      else if (wb_hit1_s) begin
         rs1_rdata_o = rd_wdata_i;
         rs1_busy_o  = (cnt_r[rs1_addr_i] != CNT_ONE);
      end
`endif
      else begin
         rs1_rdata_o = regs_r[rs1_addr_i];
         rs1_busy_o  = (rs1_addr_i != 5'd0) && (cnt_r[rs1_addr_i] != CNT_ZERO);
      end
   end

   // Read port 2, same rules as port 1.
   always_comb begin
      rs2_rdata_o = 32'd0;
      rs2_busy_o  = 1'b0;
      if (rst_i) begin
         rs2_rdata_o = 32'd0;
         rs2_busy_o  = 1'b0;
      end
`ifdef RV32I_RF_WB_BYPASS_EN
      else if (wb_hit2_s) begin
         rs2_rdata_o = rd_wdata_i;
         rs2_busy_o  = (cnt_r[rs2_addr_i] != CNT_ONE);
      end
`endif
      else begin
         rs2_rdata_o = regs_r[rs2_addr_i];
         rs2_busy_o  = (rs2_addr_i != 5'd0) && (cnt_r[rs2_addr_i] != CNT_ZERO);
      end
   end

   // A saturated destination may still issue when a commit frees a slot this cycle.
   always_comb begin
      issue_ok_o = 1'b1;
      if (rst_i) begin
         issue_ok_o = 1'b1;
      end else begin
         issue_ok_o = (cnt_r[issue_rd_i] != CNT_SAT) || dec_s[issue_rd_i];
      end
   end

   rv32i_regfile_sb_chk #(
      .NREGS(NREGS)
   ) u_chk (
      .clk        (clk_i),
      .rst        (rst_i),
      .dec_at_zero(dec_at_zero_s),
      .inc_at_sat (inc_at_sat_s)
   );

endmodule

// File: tb/tb_rv32i_regfile_sb.sv
// Randomized self-checking bench for rv32i_regfile_sb against a behavioural register/scoreboard model.
// Build with or without RV32I_RF_WB_BYPASS_EN to match the DUT.

module tb_rv32i_regfile_sb;

   localparam int SAT = 3;

   logic        clk      = 1'b0;
   logic        rst      = 1'b0;
   logic [4:0]  rs1_addr = 5'd0;
   logic [4:0]  rs2_addr = 5'd0;
   logic [4:0]  rd_addr  = 5'd0;
   logic [4:0]  issue_rd = 5'd0;
   logic        rd_we    = 1'b0;
   logic        issue    = 1'b0;
   logic        flush    = 1'b0;
   logic [31:0] rd_wdata = 32'd0;
   logic [31:0] rs1_rdata;
   logic [31:0] rs2_rdata;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        issue_ok;

   logic [31:0] m_regs [32];
   int          m_cnt  [32];
   int          n_checks = 0;
   int          n_fail   = 0;

   rv32i_regfile_sb dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .rs1_addr_i (rs1_addr),
      .rs1_rdata_o(rs1_rdata),
      .rs1_busy_o (rs1_busy),
      .rs2_addr_i (rs2_addr),
      .rs2_rdata_o(rs2_rdata),
      .rs2_busy_o (rs2_busy),
      .rd_we_i    (rd_we),
      .rd_addr_i  (rd_addr),
      .rd_wdata_i (rd_wdata),
      .issue_i    (issue),
      .issue_rd_i (issue_rd),
      .issue_ok_o (issue_ok),
      .flush_i    (flush)
   );

   always #5 clk = ~clk;

   function automatic int clamp_cnt(int v);
      if (v < 0) return 0;
      if (v > SAT) return SAT;
      return v;
   endfunction

   // Model: commits update the value, issues add one pending write, commits retire one.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) begin
            m_regs[r] <= 32'd0;
            m_cnt[r]  <= 0;
         end
      end else begin
         if (rd_we && rd_addr != 5'd0) m_regs[rd_addr] <= rd_wdata;
         for (int r = 1; r < 32; r++) begin
            if (flush) m_cnt[r] <= 0;
            else m_cnt[r] <= clamp_cnt(m_cnt[r] + ((issue && int'(issue_rd) == r) ? 1 : 0)
                                                - ((rd_we && int'(rd_addr) == r) ? 1 : 0));
         end
      end
   end

   function automatic logic [31:0] exp_rdata(logic [4:0] a);
      if (rst || a == 5'd0) return 32'd0;
`ifdef RV32I_RF_WB_BYPASS_EN
      if (rd_we && rd_addr == a) return rd_wdata;
`endif
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(logic [4:0] a);
      if (rst || a == 5'd0) return 1'b0;
`ifdef RV32I_RF_WB_BYPASS_EN
      if (rd_we && rd_addr == a) return (m_cnt[a] - 1) != 0;
`endif
      return m_cnt[a] != 0;
   endfunction

   function automatic logic exp_ok();
      if (rst) return 1'b1;
      return (m_cnt[issue_rd] != SAT) || (rd_we && rd_addr == issue_rd && issue_rd != 5'd0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Every cycle, mid-period: DUT outputs against the model.
   always @(negedge clk) begin
      chk("rs1_rdata", rs1_rdata, exp_rdata(rs1_addr));
      chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, exp_busy(rs1_addr)});
      chk("rs2_rdata", rs2_rdata, exp_rdata(rs2_addr));
      chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, exp_busy(rs2_addr)});
      chk("issue_ok", {31'd0, issue_ok}, {31'd0, exp_ok()});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue    = 1'b0;
      issue_rd = 5'd0;
      rd_we    = 1'b0;
      rd_addr  = 5'd0;
      rd_wdata = 32'd0;
      flush    = 1'b0;
   endtask

   task automatic do_issue(input logic [4:0] r);
      tick(); idle(); issue = 1'b1; issue_rd = r;
   endtask

   task automatic do_wb(input logic [4:0] r, input logic [31:0] d);
      tick(); idle(); rd_we = 1'b1; rd_addr = r; rd_wdata = d;
   endtask

   initial begin
      int r;
      #1 rst = 1'b1;
      rs1_addr = 5'd5;
      tick(); tick();
      @(negedge clk);
      chk("lit_reset_rdata", rs1_rdata, 32'd0);
      chk("lit_reset_ok", {31'd0, issue_ok}, 32'd1);
      tick(); rst = 1'b0;

      // Reset mid-run wipes a committed value
      do_issue(5'd5);
      do_wb(5'd5, 32'hDEADBEEF);
      tick(); idle(); rs1_addr = 5'd5; issue_rd = 5'd5;
      @(negedge clk);
      chk("lit_x5_before_reset", rs1_rdata, 32'hDEADBEEF);
      #1 rst = 1'b1;
      #1;
      chk("lit_x5_in_reset", rs1_rdata, 32'd0);
      chk("lit_x5_busy_in_reset", {31'd0, rs1_busy}, 32'd0);
      chk("lit_ok_in_reset", {31'd0, issue_ok}, 32'd1);
      tick(); rst = 1'b0;

      // x0 ignores writes and issues
      idle(); rd_we = 1'b1; rd_addr = 5'd0; rd_wdata = 32'hFFFFFFFF; rs1_addr = 5'd0;
      @(negedge clk);
      chk("lit_x0_write_cycle", rs1_rdata, 32'd0);
      do_issue(5'd0);
      tick(); idle();
      @(negedge clk);
      chk("lit_x0_rdata", rs1_rdata, 32'd0);
      chk("lit_x0_busy", {31'd0, rs1_busy}, 32'd0);

      // Two in-flight writes to x7
      do_issue(5'd7);
      do_issue(5'd7);
      tick(); idle(); rs1_addr = 5'd7;
      @(negedge clk);
      chk("lit_x7_busy2", {31'd0, rs1_busy}, 32'd1);
      do_wb(5'd7, 32'h000000A1);
      @(negedge clk);
      chk("lit_x7_busy_after_wb1", {31'd0, rs1_busy}, 32'd1);
      do_wb(5'd7, 32'h000000B2);
      @(negedge clk);
`ifdef RV32I_RF_WB_BYPASS_EN
      chk("lit_x7_wb2_cycle_busy", {31'd0, rs1_busy}, 32'd0);
`else
      chk("lit_x7_wb2_cycle_busy", {31'd0, rs1_busy}, 32'd1);
`endif
      tick(); idle();
      @(negedge clk);
      chk("lit_x7_busy_final", {31'd0, rs1_busy}, 32'd0);
      chk("lit_x7_value", rs1_rdata, 32'h000000B2);

      // Same-cycle issue and commit on x3 leaves the count at 1
      do_issue(5'd3);
      tick(); idle(); issue = 1'b1; issue_rd = 5'd3; rd_we = 1'b1; rd_addr = 5'd3;
      rd_wdata = 32'h33; rs1_addr = 5'd3;
      tick(); idle();
      @(negedge clk);
      chk("lit_x3_busy", {31'd0, rs1_busy}, 32'd1);
      do_wb(5'd3, 32'h34);

      // Saturated x6: blocked alone, allowed with a same-cycle commit
      do_issue(5'd6);
      do_issue(5'd6);
      do_issue(5'd6);
      tick(); idle(); issue_rd = 5'd6;
      @(negedge clk);
      chk("lit_x6_sat_ok", {31'd0, issue_ok}, 32'd0);
      tick(); idle(); issue = 1'b1; issue_rd = 5'd6; rd_we = 1'b1; rd_addr = 5'd6;
      rd_wdata = 32'h66;
      @(negedge clk);
      chk("lit_x6_sat_dec_ok", {31'd0, issue_ok}, 32'd1);

      // Flush with a concurrent commit to x9
      do_issue(5'd9);
      do_issue(5'd10);
      tick(); idle(); flush = 1'b1; rd_we = 1'b1; rd_addr = 5'd9; rd_wdata = 32'h1234;
      rs1_addr = 5'd9; rs2_addr = 5'd6;
      tick(); idle();
      @(negedge clk);
      chk("lit_flush_x9_value", rs1_rdata, 32'h00001234);
      chk("lit_flush_x9_busy", {31'd0, rs1_busy}, 32'd0);
      chk("lit_flush_x6_busy", {31'd0, rs2_busy}, 32'd0);
      tick(); idle(); rs1_addr = 5'd10;
      @(negedge clk);
      chk("lit_flush_x10_busy", {31'd0, rs1_busy}, 32'd0);

      // Commit to x4 while read port 2 looks at it
      do_issue(5'd4);
      do_wb(5'd4, 32'h11110000);
      do_issue(5'd4);
      do_wb(5'd4, 32'h55AA55AA);
      rs2_addr = 5'd4;
      @(negedge clk);
`ifdef RV32I_RF_WB_BYPASS_EN
      chk("lit_x4_same_cycle_rdata", rs2_rdata, 32'h55AA55AA);
      chk("lit_x4_same_cycle_busy", {31'd0, rs2_busy}, 32'd0);
`else
      chk("lit_x4_same_cycle_rdata", rs2_rdata, 32'h11110000);
      chk("lit_x4_same_cycle_busy", {31'd0, rs2_busy}, 32'd1);
`endif
      tick(); idle();
      @(negedge clk);
      chk("lit_x4_next_rdata", rs2_rdata, 32'h55AA55AA);
      chk("lit_x4_next_busy", {31'd0, rs2_busy}, 32'd0);

      // Random protocol-legal traffic on a small register window
      for (int c = 0; c < 3000; c++) begin
         tick(); idle();
         if ($urandom_range(0, 2) != 0) begin
            r = $urandom_range(1, 7);
            if (m_cnt[r] > 0) begin
               rd_we = 1'b1; rd_addr = 5'(r); rd_wdata = $urandom;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            rd_we = 1'b1; rd_addr = 5'd0; rd_wdata = $urandom;
         end
         r = $urandom_range(0, 7);
         issue_rd = 5'(r);
         if ((m_cnt[r] < SAT || (rd_we && int'(rd_addr) == r)) && $urandom_range(0, 1) == 1)
            issue = 1'b1;
         flush = ($urandom_range(0, 39) == 0);
         rs1_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom_range(0, 9));
         rs2_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      end

      tick(); idle();
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
